sm83_timer: RTL
===============

SM83_TIMER -- requirements
Module: sm83_timer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, listed first: clk  in  1  system clock (T-cycle rate); rst  in  1  synchronous active-high reset.
REQ-002 bus_req  in  1  CPU bus access request, one cycle per access.
REQ-003 bus_we  in  1  1 = write, 0 = read; qualified by bus_req.
REQ-004 bus_addr  in  16  CPU byte address.
REQ-005 bus_wdata  in  8  write data.
REQ-006 bus_rdata  out  8  read data, valid when bus_ack=1, else 0x00.
REQ-007 bus_ack  out  1  access accepted, one cycle.
REQ-008 irq_timer  out  1  one-cycle timer interrupt request pulse to the interrupt controller.

Function
REQ-009 Registers SHALL be: DIV at 0xFF04, TIMA at 0xFF05, TMA at 0xFF06, TAC at 0xFF07; an internal 16-bit sys_cnt SHALL increment every cycle; DIV SHALL read as sys_cnt[15:8].
REQ-010 Responder timing: for bus_req=1 with bus_addr in 0xFF04..0xFF07, bus_ack SHALL be 1 exactly one cycle later; a write SHALL take effect on the request cycle edge; read data SHALL be the register value sampled at the request cycle.
REQ-011 An address outside 0xFF04..0xFF07 SHALL produce no ack, no state change, and bus_rdata=0x00.
REQ-012 A TAC read SHALL return {5'b11111, tac[2:0]}; only tac[2:0] SHALL be writable.
REQ-013 A DIV write of any value SHALL clear sys_cnt to 0x0000 on that edge instead of incrementing it.
REQ-014 Tick source: sel_bit SHALL be sys_cnt[9], [3], [5], or [7] for tac[1:0] = 00, 01, 10, 11; tick_sig = tac[2] & sel_bit.
REQ-015 TIMA SHALL increment on each cycle where registered tick_sig_q=1 and the current tick_sig=0; this includes falling edges caused by a DIV write or a TAC write.
REQ-016 A TIMA write in the same cycle as an increment SHALL win; the increment SHALL be dropped.
REQ-017 Overflow FSM states SHALL be IDLE, OVF_WAIT and RELOAD.
REQ-018 IDLE -> OVF_WAIT: TIMA increments from 0xFF, and TIMA becomes 0x00.
REQ-019 OVF_WAIT: TIMA SHALL hold 0x00 for 4 cycles and then transition to RELOAD.
REQ-020 RELOAD: TIMA SHALL load TMA, irq_timer SHALL be 1 for that single cycle, and the FSM SHALL return to IDLE.
REQ-021 A TIMA write while in OVF_WAIT SHALL load the written value, cancel the reload and the IRQ, and return the FSM to IDLE.
REQ-022 A TIMA write in the RELOAD cycle SHALL be ignored; the TMA value SHALL win.
REQ-023 A TMA write in the RELOAD cycle SHALL make the new TMA value the reloaded value.
REQ-024 Tick edges during OVF_WAIT or RELOAD SHALL be dropped.
REQ-025 sys_cnt SHALL wrap from 0xFFFF to 0x0000 with no side effect other than normal tick edges.

Reset
REQ-026 rst SHALL clear sys_cnt, TIMA, TMA, tac, and tick_sig_q to 0, set the FSM to IDLE, and force bus_ack=0, bus_rdata=0x00, irq_timer=0 on the next cycle.
REQ-027 Reset asserted during OVF_WAIT or RELOAD SHALL abort the pending reload; no irq_timer pulse SHALL be emitted.
REQ-028 A bus request issued in the same cycle as rst SHALL be discarded with no ack.

Configuration
REQ-029 Macro SM83_TIMER_OVF_DELAY_EN SHALL select the overflow behaviour.
REQ-030 With SM83_TIMER_OVF_DELAY_EN defined: OVF_WAIT/RELOAD behaviour SHALL be as specified in REQ-017..REQ-024.
REQ-031 Without SM83_TIMER_OVF_DELAY_EN: an overflowing increment SHALL load TMA and pulse irq_timer on the same edge; OVF_WAIT and RELOAD SHALL not exist; REQ-021..REQ-023 SHALL not apply.

Verification
REQ-032 (delay on) Write TMA=0xA0, TIMA=0xFE, TAC=0x05, then wait -> TIMA=0xFF after 1st falling edge of sys_cnt[3], 0x00 at 2nd edge, reads 0x00 for 4 cycles, then 0xA0 with a single-cycle irq_timer pulse.
REQ-033 0x1234 cycles after reset, read 0xFF04 -> bus_ack one cycle later with rdata=0x12; write 0xFF04=0x77 then read -> 0x00.
REQ-034 (delay on) Write TIMA=0x55 during the 2nd OVF_WAIT cycle -> TIMA=0x55, no irq_timer, FSM in IDLE.
REQ-035 TAC=0x05, write DIV while sys_cnt[3]=1 -> TIMA increments by exactly 1.
REQ-036 Assert rst during OVF_WAIT -> all registers 0x00, irq_timer never pulses, TAC reads 0xF8.
REQ-037 Read 0xFF08 and write 0xFF03=0xAA -> no bus_ack, rdata=0x00, no register changes.

Source files
------------

// File: rtl/sm83_timer.sv
// rtl/sm83_timer.sv - SM83 DIV/TIMA/TMA/TAC timer block with bus responder
// Optional delayed overflow reload selected by SM83_TIMER_OVF_DELAY_EN.
module sm83_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [7:0]  bus_rdata,
    output logic        bus_ack,
    output logic        irq_timer
);

    logic [15:0] sys_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic        tick_q;
    logic        irq_q;

    logic        hit;
    logic        wr;
    logic        div_wr;
    logic        tima_wr;
    logic        tma_wr;
    logic        tac_wr;
    logic        sel_bit;
    logic        tick_sig;
    logic        tick_fall;
    logic [7:0]  rd_data;
    logic [7:0]  tima_d;
    logic        irq_d;

    assign hit     = bus_req && (bus_addr[15:2] == 14'h3FC1);
    assign wr      = hit && bus_we;
    assign div_wr  = wr && (bus_addr[1:0] == 2'd0);
    assign tima_wr = wr && (bus_addr[1:0] == 2'd1);
    assign tma_wr  = wr && (bus_addr[1:0] == 2'd2);
    assign tac_wr  = wr && (bus_addr[1:0] == 2'd3);

    always_comb begin
        sel_bit = 1'b0;
        case (tac[1:0])
            2'd0: sel_bit = sys_cnt[9];
            2'd1: sel_bit = sys_cnt[3];
            2'd2: sel_bit = sys_cnt[5];
            2'd3: sel_bit = sys_cnt[7];
            default: sel_bit = 1'b0;
        endcase
    end

    // Edges produced by DIV clears or TAC changes fall out of this naturally.
    assign tick_sig  = tac[2] & sel_bit;
    assign tick_fall = tick_q & ~tick_sig;

    always_comb begin
        rd_data = 8'h00;
        case (bus_addr[1:0])
            2'd0: rd_data = sys_cnt[15:8];
            2'd1: rd_data = tima;
            2'd2: rd_data = tma;
            2'd3: rd_data = {5'b11111, tac};
            default: rd_data = 8'h00;
        endcase
    end

`ifdef SM83_TIMER_OVF_DELAY_EN
    typedef enum logic [1:0] {IDLE, OVF_WAIT, RELOAD} ovf_state_t;
    ovf_state_t state;
    ovf_state_t state_d;
    logic [1:0] wait_cnt;
    logic [1:0] wait_cnt_d;

    always_comb begin
        tima_d     = tima;
        irq_d      = 1'b0;
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            IDLE: begin
                if (tima_wr) begin
                    tima_d = bus_wdata;
                end else if (tick_fall) begin
                    if (tima == 8'hFF) begin
                        tima_d     = 8'h00;
                        state_d    = OVF_WAIT;
                        wait_cnt_d = 2'd0;
                    end else begin
                        tima_d = tima + 8'd1;
                    end
                end
            end
            OVF_WAIT: begin
                if (tima_wr) begin
                    tima_d  = bus_wdata;
                    state_d = IDLE;
                end else if (wait_cnt == 2'd3) begin
                    tima_d  = tma_wr ? bus_wdata : tma;
                    irq_d   = 1'b1;
                    state_d = RELOAD;
                end else begin
                    wait_cnt_d = wait_cnt + 2'd1;
                end
            end
            RELOAD: begin
                // TIMA already holds TMA; only a fresh TMA write may replace it.
                if (tma_wr) begin
                    tima_d = bus_wdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        tima_d = tima;
        irq_d  = 1'b0;
        if (tima_wr) begin
            tima_d = bus_wdata;
        end else if (tick_fall) begin
            if (tima == 8'hFF) begin
                tima_d = tma;
                irq_d  = 1'b1;
            end else begin
                tima_d = tima + 8'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sys_cnt   <= 16'h0000;
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
            bus_ack   <= 1'b0;
            bus_rdata <= 8'h00;
        end else begin
            sys_cnt   <= div_wr ? 16'h0000 : sys_cnt + 16'd1;
            tima      <= tima_d;
            tick_q    <= tick_sig;
            irq_q     <= irq_d;
            bus_ack   <= hit;
            bus_rdata <= (hit && !bus_we) ? rd_data : 8'h00;
            if (tma_wr) begin
                tma <= bus_wdata;
            end
            if (tac_wr) begin
                tac <= bus_wdata[2:0];
            end
        end
    end

    // A reset landing on the pulse cycle suppresses it.
    assign irq_timer = irq_q & ~rst;

endmodule
